// File: rtl/truth_table_checker_if.sv
// Bus between truth_table_checker and the lab top-level holding the reference and candidate blocks.
// The checker takes the master side; the lab top-level takes the slave side.
interface truth_table_checker_if #(
  parameter int unsigned N = 3
);
  logic         start;
  logic         ref_out;
  logic         dut_out;
  logic [N-1:0] stim;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         fail_seen;
  logic [N-1:0] first_fail;

  modport master (
    input  start, ref_out, dut_out,
    output stim, busy, done, pass, err_count, fail_seen, first_fail
  );

  modport slave (
    output start, ref_out, dut_out,
    input  stim, busy, done, pass, err_count, fail_seen, first_fail
  );
endinterface

// File: rtl/truth_table_checker.sv
// Sweeps all 2^N input vectors and compares reference vs. candidate outputs on each one.
// Optional macro TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_checker #(
  parameter int unsigned N      = 3,
  parameter int unsigned SETTLE = 0
) (
  input logic                  clk,
  input logic                  rst,
  truth_table_checker_if.master bus
);
  localparam int unsigned CntW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CntW-1:0] SettleCnt = CntW'(SETTLE);
  localparam logic [N-1:0]    LastVec   = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    stim_q, stim_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N:0]      err_q, err_d;
  logic [N-1:0]    first_q, first_d;
  logic            seen_q, seen_d;
  logic            pass_q, pass_d;
  logic            mismatch;

  // Case inequality so an X/Z from either block is reported as a failure.
  assign mismatch = (bus.ref_out !== bus.dut_out);

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    first_d = first_q;
    seen_d  = seen_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d = StRun;
          stim_d  = '0;
          cnt_d   = '0;
          err_d   = '0;
          first_d = '0;
          seen_d  = 1'b0;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        if (cnt_q == SettleCnt) begin
          cnt_d = '0;
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!seen_q) begin
              first_d = stim_q;
              seen_d  = 1'b1;
            end
          end
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
          if (mismatch) begin
            state_d = StDone;
            pass_d  = 1'b0;
          end else if (stim_q == LastVec) begin
            state_d = StDone;
            pass_d  = (err_q == '0);
          end else begin
            stim_d = stim_q + 1'b1;
          end
`else
          if (stim_q == LastVec) begin
            state_d = StDone;
            pass_d  = (err_q == '0) && !mismatch;
          end else begin
            stim_d = stim_q + 1'b1;
          end
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stim_q  <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      first_q <= '0;
      seen_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      first_q <= first_d;
      seen_q  <= seen_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.busy       = (state_q == StRun);
  assign bus.done       = (state_q == StDone);
  assign bus.pass       = pass_q;
  assign bus.err_count  = err_q;
  assign bus.fail_seen  = seen_q;
  assign bus.first_fail = first_q;
endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: two instances (SETTLE=0 and SETTLE=2) driven by behavioural
// X/Y/Z functions; expected sweep results are queued at START and compared when DONE rises.
module tb_truth_table_checker;
  localparam int unsigned N = 3;
`ifdef TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN
  localparam bit StopMode = 1'b1;
`else
  localparam bit StopMode = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start_a, start_b, use_b, xval;
  int   fsel;

  truth_table_checker_if #(.N(N)) bus_a ();
  truth_table_checker_if #(.N(N)) bus_b ();

  truth_table_checker #(.N(N), .SETTLE(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  truth_table_checker #(.N(N), .SETTLE(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  // REF = XY + X'Z + YZ with X = v[2], Y = v[1], Z = v[0].
  function automatic logic fref(input logic [2:0] v);
    return (v[2] & v[1]) | (~v[2] & v[0]) | (v[1] & v[0]);
  endfunction

  // sel 0: XY + X'Z (equivalent), 1: XY, 2: reference with X driven on vector 001.
  function automatic logic fdut(input logic [2:0] v, input int sel, input logic xv);
    case (sel)
      0:       return (v[2] & v[1]) | (~v[2] & v[0]);
      1:       return v[2] & v[1];
      default: return (v == 3'b001) ? xv : fref(v);
    endcase
  endfunction

  assign bus_a.start   = start_a;
  assign bus_a.ref_out = fref(bus_a.stim);
  assign bus_a.dut_out = fdut(bus_a.stim, fsel, xval);
  assign bus_b.start   = start_b;
  assign bus_b.ref_out = fref(bus_b.stim);
  assign bus_b.dut_out = fdut(bus_b.stim, fsel, xval);

  logic [2:0] o_stim, o_first;
  logic [3:0] o_err;
  logic       o_busy, o_done, o_pass, o_seen;
  assign o_stim  = use_b ? bus_b.stim       : bus_a.stim;
  assign o_first = use_b ? bus_b.first_fail : bus_a.first_fail;
  assign o_err   = use_b ? bus_b.err_count  : bus_a.err_count;
  assign o_busy  = use_b ? bus_b.busy       : bus_a.busy;
  assign o_done  = use_b ? bus_b.done       : bus_a.done;
  assign o_pass  = use_b ? bus_b.pass       : bus_a.pass;
  assign o_seen  = use_b ? bus_b.fail_seen  : bus_a.fail_seen;

  typedef struct {
    int         done_edge;
    logic [2:0] stim;
    logic [3:0] err;
    logic [2:0] first;
    logic       seen;
    logic       pass;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int sel, input int settle);
    exp_t       e;
    logic [2:0] v;
    logic       r, d;
    bit         stopped;
    e.done_edge = 8 * (settle + 1);
    e.stim      = 3'd7;
    e.err       = '0;
    e.first     = '0;
    e.seen      = 1'b0;
    stopped     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!stopped) begin
        v = 3'(k);
        r = fref(v);
        d = fdut(v, sel, xval);
        if (r !== d) begin
          e.err = e.err + 4'd1;
          if (!e.seen) begin
            e.first = v;
            e.seen  = 1'b1;
          end
          if (StopMode) begin
            e.done_edge = (k + 1) * (settle + 1);
            e.stim      = v;
            stopped     = 1'b1;
          end
        end
      end
    end
    e.pass = (e.err == 4'd0);
    return e;
  endfunction

  // Pulse START so that it is sampled at "edge 0"; returns 1 time unit after that edge.
  task automatic pulse_start(input int sel, input bit b, input bit push);
    fsel  = sel;
    use_b = b;
    if (push) sb.push_back(model(sel, b ? 2 : 0));
    @(negedge clk);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Follows the sweep edge by edge; optionally re-pulses START so it is sampled at edge repulse.
  task automatic wait_done(input int repulse);
    exp_t e;
    int   n, settle;
    bit   got;
    e      = sb.pop_front();
    settle = use_b ? 2 : 0;
    n      = 0;
    got    = 1'b0;
    while (!got && n < 200) begin
      if (repulse > 0 && n + 1 == repulse) begin
        if (use_b) start_b = 1'b1;
        else       start_a = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
      start_a = 1'b0;
      start_b = 1'b0;
      if (o_done) got = 1'b1;
      else begin
        check_eq("stim_step", o_stim, n / (settle + 1));
        check_eq("busy_run", o_busy, 1);
      end
    end
    check_eq("done_seen", o_done, 1);
    check_eq("done_edge", n, e.done_edge);
    check_eq("busy_done", o_busy, 0);
    check_eq("stim_final", o_stim, e.stim);
    check_eq("err_count", o_err, e.err);
    check_eq("first_fail", o_first, e.first);
    check_eq("fail_seen", o_seen, e.seen);
    check_eq("pass", o_pass, e.pass);
  endtask

  initial begin
    xval    = 1'bx;
    rst     = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    use_b   = 1'b0;
    fsel    = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_a", {bus_a.stim, bus_a.busy, bus_a.done, bus_a.pass, bus_a.err_count,
                       bus_a.fail_seen, bus_a.first_fail}, 0);
    check_eq("rst_b", {bus_b.stim, bus_b.busy, bus_b.done, bus_b.pass, bus_b.err_count,
                       bus_b.fail_seen, bus_b.first_fail}, 0);
    rst = 1'b0;

    // Non-equivalent DUT with a START sampled mid-sweep at edge 3.
    pulse_start(1, 1'b0, 1'b1);
    wait_done(3);

    // Restart from DONE must clear results on the next edge.
    pulse_start(0, 1'b0, 1'b1);
    check_eq("restart_done", o_done, 0);
    check_eq("restart_err", o_err, 0);
    check_eq("restart_stim", o_stim, 0);
    check_eq("restart_busy", o_busy, 1);
    wait_done(0);

    // X on DUT_OUT at vector 001.
    pulse_start(2, 1'b0, 1'b1);
    wait_done(0);

    // Reset sampled at edge 4 of a sweep.
    pulse_start(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid", {o_stim, o_busy, o_done, o_pass, o_err, o_seen, o_first}, 0);
    @(posedge clk);
    #1;
    check_eq("rst_idle", {o_busy, o_done}, 0);
    pulse_start(1, 1'b0, 1'b1);
    wait_done(0);

    // SETTLE=2 instance.
    pulse_start(0, 1'b1, 1'b1);
    wait_done(0);
    pulse_start(1, 1'b1, 1'b1);
    wait_done(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/truth_table_checker.md
# truth_table_checker

Self-checking stimulus driver for the team's small combinational logic blocks, such as the three-input X/Y/Z function modules. The checker walks every input vector across one reference implementation and one candidate implementation, and compares their outputs on every vector. It counts mismatches and records the first failing vector. Both implementations sit beside it in a lab top-level, driven from the same `STIM` bus.

## Interface
- `N`, default 3: number of function inputs; `STIM` width.
- `SETTLE`, default 0: extra wait cycles per vector before its outputs are sampled.
- `CLK  in  1`: single clock; everything is rising-edge.
- `RST  in  1`: synchronous, active-high reset.
- `START  in  1`: begin a sweep. Honoured only in IDLE or DONE.
- `REF_OUT  in  1`: output of the reference (known-good) implementation.
- `DUT_OUT  in  1`: output of the implementation under check.
- `STIM  out  N`: current vector, registered. Bit mapping is `STIM[N-1]` to the first input (X), down to `STIM[0]` to the last input (Z).
- `BUSY  out  1`: sweep in progress.
- `DONE  out  1`: sweep finished. Held until the next accepted START or RST.
- `PASS  out  1`: DONE with zero mismatches.
- `ERR_COUNT  out  N+1`: number of mismatching vectors. Range 0..2^N.
- `FAIL_SEEN  out  1`: FIRST_FAIL is valid.
- `FIRST_FAIL  out  N`: STIM value at the first mismatch. 0 if none.

## Operation
- **States:**
  - IDLE: entered after reset.
  - RUN: the sweep.
  - DONE: results held.
- **IDLE/DONE to RUN** when START=1:
  - STIM, ERR_COUNT, FIRST_FAIL, FAIL_SEEN, DONE, PASS and the wait counter clear to 0.
  - BUSY goes to 1.
- **RUN, vector loop:**
  - The wait counter counts 0..SETTLE.
  - At the edge where it equals SETTLE, REF_OUT and DUT_OUT are compared with case inequality, so an X or Z on either output counts as a mismatch.
  - On a mismatch, ERR_COUNT increments. If FAIL_SEEN=0, FIRST_FAIL is set to STIM and FAIL_SEEN is set to 1.
  - On the same edge, STIM increments and the wait counter resets to 0.
- **RUN to DONE:** on the compare edge of vector 2^N-1, STIM holds at 2^N-1 and does not wrap.
  - BUSY goes to 0 and DONE goes to 1.
  - PASS is set from the final error count, including that edge's compare result.
- **START during RUN:** ignored.
- **START in DONE:** restarts a fresh sweep.
- **RST at any time, including mid-sweep:**
  - On the next edge, all outputs go to 0 and the state goes to IDLE.
  - This reset value applies to every output.
- ERR_COUNT cannot overflow, because its width is N+1.

## Timing
- STIM changes only on clock edges. The compared outputs are those settled during the cycle(s) STIM was stable.
- Each vector occupies SETTLE+1 cycles.
- Vector k is compared at edge (k+1)·(SETTLE+1) after the edge that sampled START.
- DONE rises (SETTLE+1)·2^N edges after the START-sampling edge. For N=3 and SETTLE=0 this is 8 edges.
- PASS, ERR_COUNT and FIRST_FAIL are final in the same cycle DONE rises.

## Configuration
- Macro: `TRUTH_TABLE_CHECKER_STOP_ON_FAIL_EN`.
- **Defined:** the first mismatch ends the sweep.
  - At that compare edge the state goes to DONE, with ERR_COUNT=1, PASS=0 and FAIL_SEEN=1.
  - STIM holds the failing vector; it is not incremented.
- **Undefined:** the full 2^N sweep always runs and ERR_COUNT is the total number of mismatches.

## Test plan
- **Equivalent functions.** REF = XY+X'Z+YZ, DUT = XY+X'Z, N=3, SETTLE=0, START pulsed.
  - Required: DONE at edge 8, PASS=1, ERR_COUNT=0, FAIL_SEEN=0, STIM=3'b111.
- **Non-equivalent function, macro undefined.** DUT = XY.
  - Mismatches occur at 001 and 011.
  - Required: DONE at edge 8, ERR_COUNT=2, FIRST_FAIL=3'b001, FAIL_SEEN=1, PASS=0.
- **Same DUT, macro defined.**
  - Required: DONE at edge 2, ERR_COUNT=1, FIRST_FAIL=3'b001, STIM=3'b001.
- **SETTLE=2 with equivalent functions.**
  - Required: STIM steps every 3 cycles, DONE at edge 24, PASS=1.
- **RST asserted mid-sweep.** RST=1 at edge 4.
  - Required: all outputs 0 and state IDLE after the next edge.
  - A new START then gives a full sweep with correct results.
- **START during RUN and in DONE.** START re-pulsed at edge 3, and again after DONE.
  - Required: the edge-3 pulse is ignored, so DONE still arrives at edge 8.
  - The pulse after DONE restarts: DONE, ERR_COUNT and STIM clear on the next edge.
- **X on DUT_OUT.** DUT_OUT=1'bx for one vector.
  - Required: counted as a mismatch, ERR_COUNT=1.
